// File: rtl/simp_fun_stream.sv
// rtl/simp_fun_stream.sv - streaming add/sub/max/min unit with elastic valid/ready pipeline
module simp_fun_stream #(
    parameter int WIDTH      = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       op_in,
    input  logic             sat_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c_out,
    output logic             ovf_out
);

    logic [NUM_STAGES-1:0] v;
    logic [NUM_STAGES-1:0] ovf;
    logic [WIDTH-1:0]      c [NUM_STAGES];
    logic [NUM_STAGES-1:0] load;
    logic [NUM_STAGES-1:0] adv;

    logic [WIDTH:0]        sum;
    logic [WIDTH:0]        diff;
    logic [WIDTH-1:0]      res;
    logic                  res_ovf;

    // The carry/borrow bit of the WIDTH+1 result is the overflow flag for add/sub.
    always_comb begin
        sum     = {1'b0, a_in} + {1'b0, b_in};
        diff    = {1'b0, a_in} - {1'b0, b_in};
        res     = sum[WIDTH-1:0];
        res_ovf = 1'b0;
        case (op_in)
            2'b00: begin
                res_ovf = sum[WIDTH];
                res     = (sum[WIDTH] && sat_in) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            end
            2'b01: begin
                res_ovf = diff[WIDTH];
                res     = (diff[WIDTH] && sat_in) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
            end
            2'b10:   res = (a_in > b_in) ? a_in : b_in;
            default: res = (a_in < b_in) ? a_in : b_in;
        endcase
    end

    // Ready ripples back from the consumer so empty slots collapse bubbles.
    always_comb begin
        load = '0;
        adv  = '0;
        adv[NUM_STAGES-1]  = v[NUM_STAGES-1] & out_ready;
        load[NUM_STAGES-1] = ~v[NUM_STAGES-1] | adv[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            adv[i]  = v[i] & load[i+1];
            load[i] = ~v[i] | adv[i];
        end
    end

    assign in_ready = load[0] & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v   <= '0;
            ovf <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                c[i] <= '0;
            end
        end else begin
            if (load[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    c[0]   <= res;
                    ovf[0] <= res_ovf;
                end
            end
            // Payload only moves with a valid bit, so empty slots keep their old data.
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (load[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        c[i]   <= c[i-1];
                        ovf[i] <= ovf[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = v[NUM_STAGES-1];
    assign c_out     = c[NUM_STAGES-1];
    assign ovf_out   = ovf[NUM_STAGES-1];

endmodule

// File: tb/tb_simp_fun_stream.sv
// tb/tb_simp_fun_stream.sv - directed and randomized checks of simp_fun_stream at depths 1, 2 and 3
module tb_simp_fun_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv, ir, ov, ordy, ovf, sat;
    logic [7:0] a, b, c;
    logic [1:0] op;

    logic       riv [2];
    logic       rir [2];
    logic       rov [2];
    logic       rordy [2];
    logic       rovf [2];
    logic       rsat [2];
    logic [7:0] ra [2];
    logic [7:0] rb [2];
    logic [7:0] rc [2];
    logic [1:0] rop [2];

    int checks = 0;
    int errors = 0;

    simp_fun_stream #(.WIDTH(8), .NUM_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a_in(a), .b_in(b),
        .op_in(op), .sat_in(sat), .out_valid(ov), .out_ready(ordy), .c_out(c), .ovf_out(ovf)
    );

    simp_fun_stream #(.WIDTH(8), .NUM_STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(riv[0]), .in_ready(rir[0]), .a_in(ra[0]), .b_in(rb[0]),
        .op_in(rop[0]), .sat_in(rsat[0]), .out_valid(rov[0]), .out_ready(rordy[0]),
        .c_out(rc[0]), .ovf_out(rovf[0])
    );

    simp_fun_stream #(.WIDTH(8), .NUM_STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(riv[1]), .in_ready(rir[1]), .a_in(ra[1]), .b_in(rb[1]),
        .op_in(rop[1]), .sat_in(rsat[1]), .out_valid(rov[1]), .out_ready(rordy[1]),
        .c_out(rc[1]), .ovf_out(rovf[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic [1:0] mop, input logic ms);
        int         s;
        logic [7:0] r;
        logic       o;
        o = 1'b0;
        r = 8'd0;
        case (mop)
            2'd0: begin
                s = int'(ma) + int'(mb);
                o = (s > 255);
                r = o ? (ms ? 8'hFF : 8'(s - 256)) : 8'(s);
            end
            2'd1: begin
                s = int'(ma) - int'(mb);
                o = (ma < mb);
                r = o ? (ms ? 8'h00 : 8'(s + 256)) : 8'(s);
            end
            2'd2:    r = (ma >= mb) ? ma : mb;
            default: r = (ma <= mb) ? ma : mb;
        endcase
        return {o, r};
    endfunction

    task automatic one_shot(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                            input logic ts, input logic [7:0] ec, input logic eo, input string tag);
        @(negedge clk);
        iv = 1'b1; a = ta; b = tb; op = top; sat = ts; ordy = 1'b1;
        #1 check({tag, "_in_ready"}, ir, 1);
        @(posedge clk);
        #1;
        iv = 1'b0;
        check({tag, "_latency"}, ov, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, ov, 1);
        check({tag, "_c"}, c, ec);
        check({tag, "_ovf"}, ovf, eo);
        @(posedge clk);
        #1 check({tag, "_drained"}, ov, 0);
    endtask

    logic [7:0] bpa [4];
    logic [7:0] bpb [4];
    logic [1:0] bpo [4];
    logic [7:0] bpe [4];
    logic [7:0] gotc [8];
    logic [7:0] tpa [16];
    logic [7:0] tpb [16];
    logic [1:0] tpo [16];
    logic       tps [16];
    logic [8:0] tpe [16];
    logic [8:0] mem [2][2048];
    int         wr [2];
    int         rd [2];
    logic       stall [2];
    logic [8:0] lastv [2];
    logic       acc2 [2];
    int         j, got;
    logic       acc;

    initial begin
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; a = 8'd0; b = 8'd0; op = 2'd0; sat = 1'b0;
        for (int k = 0; k < 2; k++) begin
            riv[k] = 1'b0; rordy[k] = 1'b0; ra[k] = 8'd0; rb[k] = 8'd0; rop[k] = 2'd0; rsat[k] = 1'b0;
        end

        #12;
        check("rst_out_valid", ov, 0);
        check("rst_c_out", c, 0);
        check("rst_ovf_out", ovf, 0);
        check("rst_in_ready", ir, 0);
        check("rst_n1_in_ready", rir[0], 0);
        check("rst_n3_out_valid", rov[1], 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("release_in_ready", ir, 1);

        one_shot(8'd5,   8'd7,   2'd0, 1'b0, 8'd12,  1'b0, "add_5_7");
        one_shot(8'd10,  8'd20,  2'd1, 1'b0, 8'd246, 1'b1, "sub_wrap");
        one_shot(8'd100, 8'd50,  2'd2, 1'b0, 8'd100, 1'b0, "max");
        one_shot(8'd200, 8'd100, 2'd0, 1'b0, 8'd44,  1'b1, "add_wrap");
        one_shot(8'd200, 8'd100, 2'd0, 1'b1, 8'd255, 1'b1, "add_sat");
        one_shot(8'd3,   8'd9,   2'd1, 1'b1, 8'd0,   1'b1, "sub_sat");
        one_shot(8'd3,   8'd9,   2'd3, 1'b1, 8'd3,   1'b0, "min");

        // Backpressure: 4 offered against a depth-2 pipe held stalled.
        bpa = '{8'd1, 8'd10, 8'd9, 8'd9};
        bpb = '{8'd2, 8'd3,  8'd4, 8'd4};
        bpo = '{2'd0, 2'd1,  2'd2, 2'd3};
        bpe = '{8'd3, 8'd7,  8'd9, 8'd4};
        j = 0;
        got = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            ordy = (cyc >= 6);
            if (j < 4) begin
                iv = 1'b1; a = bpa[j]; b = bpb[j]; op = bpo[j]; sat = 1'b0;
            end else begin
                iv = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                check("bp_first_valid", ov, 1);
                check("bp_first_c", c, 3);
            end
            if (cyc == 5) begin
                check("bp_accepted", j, 2);
                check("bp_full_in_ready", ir, 0);
                check("bp_stall_c", c, 3);
            end
            if (cyc == 6) check("bp_simul_in_ready", ir, 1);
            acc = iv & ir;
            if (ov && ordy) begin
                if (got < 8) gotc[got] = c;
                got++;
            end
            @(posedge clk);
            if (acc) j++;
        end
        iv = 1'b0;
        check("bp_out_count", got, 4);
        for (int k = 0; k < 4; k++) check($sformatf("bp_order_%0d", k), gotc[k], bpe[k]);

        // Full throughput with out_ready held high.
        for (int k = 0; k < 16; k++) begin
            tpa[k] = 8'($urandom_range(0, 255));
            tpb[k] = 8'($urandom_range(0, 255));
            tpo[k] = 2'($urandom_range(0, 3));
            tps[k] = 1'($urandom_range(0, 1));
            tpe[k] = model(tpa[k], tpb[k], tpo[k], tps[k]);
        end
        ordy = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc < 16) begin
                iv = 1'b1; a = tpa[cyc]; b = tpb[cyc]; op = tpo[cyc]; sat = tps[cyc];
            end else begin
                iv = 1'b0;
            end
            #1;
            if (cyc < 16) check("tp_in_ready", ir, 1);
            if (cyc >= 2 && cyc < 18) begin
                check("tp_valid", ov, 1);
                check("tp_result", {ovf, c}, tpe[cyc-2]);
            end else begin
                check("tp_idle", ov, 0);
            end
        end
        iv = 1'b0;

        // Reset with two transactions in flight.
        ordy = 1'b0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk);
            iv = 1'b1; a = 8'd50; b = 8'd60; op = 2'd0; sat = 1'b0;
        end
        @(negedge clk);
        iv = 1'b0;
        #1 check("mid_preload_valid", ov, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", ov, 0);
        check("mid_rst_in_ready", ir, 0);
        @(negedge clk);
        rst = 1'b0;
        ordy = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            #1 check("mid_no_stale", ov, 0);
        end
        one_shot(8'd1, 8'd1, 2'd0, 1'b0, 8'd2, 1'b0, "post_rst_add");

        // Random valid/ready at depths 1 and 3, scoreboarded against the model.
        for (int k = 0; k < 2; k++) begin
            wr[k] = 0; rd[k] = 0; stall[k] = 1'b0; acc2[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 20000 && (rd[0] < 1000 || rd[1] < 1000); cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rordy[k] = 1'($urandom_range(0, 1));
                if (!riv[k] && wr[k] < 1000 && $urandom_range(0, 1) == 1) begin
                    riv[k]  = 1'b1;
                    ra[k]   = 8'($urandom_range(0, 255));
                    rb[k]   = 8'($urandom_range(0, 255));
                    rop[k]  = 2'($urandom_range(0, 3));
                    rsat[k] = 1'($urandom_range(0, 1));
                end
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                acc2[k] = riv[k] & rir[k];
                if (stall[k]) begin
                    check($sformatf("n%0d_stall_valid", k * 2 + 1), rov[k], 1);
                    check($sformatf("n%0d_stall_data", k * 2 + 1), {rovf[k], rc[k]}, lastv[k]);
                end
                if (rov[k] && rordy[k]) begin
                    check($sformatf("n%0d_no_spurious", k * 2 + 1), rd[k] < wr[k], 1);
                    check($sformatf("n%0d_result", k * 2 + 1), {rovf[k], rc[k]}, mem[k][rd[k]]);
                    rd[k]++;
                    stall[k] = 1'b0;
                end else if (rov[k]) begin
                    stall[k] = 1'b1;
                    lastv[k] = {rovf[k], rc[k]};
                end else begin
                    stall[k] = 1'b0;
                end
                if (acc2[k]) begin
                    mem[k][wr[k]] = model(ra[k], rb[k], rop[k], rsat[k]);
                    wr[k]++;
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) if (acc2[k]) riv[k] = 1'b0;
        end
        check("n1_done", rd[0], 1000);
        check("n3_done", rd[1], 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simp_fun_stream.md
# simp_fun_stream

Parametrised, streaming successor to the basic registered two-operand function block. It accepts operand pairs with a per-transaction opcode and saturation mode over a valid/ready handshake. It computes add, subtract, max or min at WIDTH bits and returns the result plus an overflow flag through an elastic pipeline of configurable depth with full backpressure. It sits between any upstream operand producer and downstream consumer in the basic_logic datapath demos.

## Interface
- WIDTH, 8: operand/result width in bits (≥2)
- NUM_STAGES, 2: pipeline depth = latency in cycles (≥1)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand pair presented
- in_ready  output  1  block can accept this cycle
- a_in  input  WIDTH  operand A, unsigned
- b_in  input  WIDTH  operand B, unsigned
- op_in  input  2  00 add, 01 sub, 10 max, 11 min
- sat_in  input  1  1 = saturate on overflow, 0 = wrap
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts this cycle
- c_out  output  WIDTH  result
- ovf_out  output  1  overflow/borrow occurred (reported even when saturated)

## Operation
- Transfer on either side occurs on a rising edge where valid and ready are both 1.
- Stage 0 captures inputs and computes the result. Stages 1..NUM_STAGES-1 are pure delay registers, each holding {v, c, ovf}.
- Arithmetic is unsigned, computed at WIDTH+1 bits:
  - add: s = a+b; ovf = s[WIDTH]; result = sat ? all-ones : s[WIDTH-1:0] when ovf
  - sub: d = a-b; ovf = (a<b); result = sat ? 0 : d[WIDTH-1:0] when ovf
  - max/min: result = larger/smaller operand; ovf = 0; sat_in ignored
- Elastic pipeline with bubble collapse. With v[N] = 1 and out_ready = 1 for last stage N:
  - adv[last] = v[last] & out_ready
  - stage i may load when !v[i] | adv[i]
  - adv[i] = v[i] & (stage i+1 may load)
  - in_ready = (!v[0] | adv[0]) & !rst
- A stage that loads takes the upstream stage's contents. The upstream valid bit moves with the data.
- A stage that is neither loading nor advancing holds its contents. A stage that advances without loading clears v.
- out_valid = v[last]; c_out and ovf_out come from the last stage.
- Once out_valid is asserted, c_out and ovf_out are stable until the transfer completes (AXI-style; no retraction).
- No transaction is ever dropped or duplicated; output order equals input order.

## Timing
- Reset (asynchronous assert, synchronous-release use): all v = 0, all c = 0, all ovf = 0.
  - So out_valid = 0, c_out = 0, ovf_out = 0; in_ready = 0 while rst = 1.
- Reset mid-operation discards all in-flight transactions immediately, with no output transfer.
- After rst deasserts, in_ready = 1 in the same cycle (combinational from !rst).
- Latency: a transaction accepted at edge k appears with out_valid = 1 after edge k+NUM_STAGES-1, and is transferable at edge k+NUM_STAGES if out_ready = 1.
- Throughput: 1 transaction/cycle with out_ready held at 1.
- Full: with all NUM_STAGES stages valid and out_ready = 0, in_ready = 0. Capacity is exactly NUM_STAGES transactions.
- Simultaneous events: when full and out_ready = 1, in_ready = 1 in the same cycle. Accept and emit on the same edge, and occupancy is unchanged.
- in_ready depends combinationally on out_ready through the valid chain. This is the intended design; there is no skid register.
- Inputs are sampled only on accepted edges; a_in, b_in, op_in and sat_in are don't-care otherwise.

## Test plan
- Reset then stream, out_ready = 1, WIDTH = 8, NUM_STAGES = 2:
  - (5,7,add) -> 12, ovf = 0, two cycles after acceptance
  - (10,20,sub,wrap) -> 246, ovf = 1
  - (100,50,max) -> 100
- Overflow modes:
  - (200,100,add,sat = 0) -> 44, ovf = 1
  - (200,100,add,sat = 1) -> 255, ovf = 1
  - (3,9,sub,sat = 1) -> 0, ovf = 1
  - (3,9,min) -> 3, ovf = 0
- Backpressure: hold out_ready = 0 and offer 4 transactions.
  - Exactly 2 are accepted, then in_ready = 0.
  - Release out_ready: all 4 results are emitted in order with no loss or duplication, and c_out is stable while stalled.
- Full-throughput stream: 16 back-to-back random transactions with out_ready = 1.
  - in_ready stays 1 throughout.
  - Results match the reference model at one per cycle after the 2-cycle fill.
- Random in_valid/out_ready (50% each) over 1000 transactions for NUM_STAGES ∈ {1,3}.
  - Scoreboard shows an ordered exact match.
- Reset mid-stream: assert rst with 2 transactions in flight.
  - out_valid drops immediately and in_ready = 0.
  - After release, no stale result ever appears, and the next accepted (1,1,add) returns 2.
